// File: rtl/tl_mon_pkg.sv
// Shared definitions for the TileLink in-flight monitor: opcodes, error codes
// and the beats-per-message helper.
package tl_mon_pkg;

  localparam logic [2:0] A_PUT_FULL        = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] A_GET             = 3'd4;
  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

  typedef enum logic [2:0] {
    ERR_NONE           = 3'd0,
    ERR_ILLEGAL_OPCODE = 3'd1,
    ERR_DUP_SOURCE     = 3'd2,
    ERR_A_BURST_CHANGE = 3'd3,
    ERR_UNEXPECTED_D   = 3'd4,
    ERR_RESP_MISMATCH  = 3'd5,
    ERR_D_BURST_CHANGE = 3'd6
  } err_e;

  // Single-beat opcodes always take one beat regardless of size.
  function automatic int unsigned beat_count(input int unsigned size,
                                             input logic        multi,
                                             input int unsigned beat_log2);
    if (multi && (size > beat_log2)) return 32'd1 << (size - beat_log2);
    return 32'd1;
  endfunction

endpackage

// File: rtl/tl_beat_counter.sv
// Per-channel beat tracker: flags first/last beat of a message and holds the
// opcode/size/source captured on its first beat.
module tl_beat_counter
  import tl_mon_pkg::*;
#(
  parameter int unsigned SIZE_W   = 4,
  parameter int unsigned SOURCE_W = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                fire,
  input  logic [CNT_W-1:0]    beats,
  input  logic [2:0]          opcode,
  input  logic [SIZE_W-1:0]   size,
  input  logic [SOURCE_W-1:0] source,
  output logic                first,
  output logic                last,
  output logic [2:0]          lat_opcode,
  output logic [SIZE_W-1:0]   lat_size,
  output logic [SOURCE_W-1:0] lat_source
);

  // Beats still owed after the current one; zero means idle.
  logic [CNT_W-1:0] remaining;

  assign first = (remaining == '0);
  assign last  = first ? (beats == CNT_W'(1)) : (remaining == CNT_W'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      remaining  <= '0;
      lat_opcode <= '0;
      lat_size   <= '0;
      lat_source <= '0;
    end else if (fire) begin
      if (first) begin
        remaining  <= beats - CNT_W'(1);
        lat_opcode <= opcode;
        lat_size   <= size;
        lat_source <= source;
      end else begin
        remaining <= remaining - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/tl_inflight_monitor.sv
// TileLink A/D protocol monitor: tracks outstanding sources, checks responses
// and burst consistency, and captures the first error plus a saturating count.
module tl_inflight_monitor
  import tl_mon_pkg::*;
#(
  parameter int unsigned SOURCE_W  = 4,
  parameter int unsigned SIZE_W    = 4,
  parameter int unsigned BEAT_LOG2 = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                a_valid,
  input  logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [SIZE_W-1:0]   a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic                d_valid,
  input  logic                d_ready,
  input  logic [2:0]          d_opcode,
  input  logic [SIZE_W-1:0]   d_size,
  input  logic [SOURCE_W-1:0] d_source,
  input  logic                clear_err,
  output logic                err_valid,
  output logic [2:0]          err_code,
  output logic [SOURCE_W-1:0] err_source,
  output logic [7:0]          err_count,
  output logic [SOURCE_W:0]   inflight_count
);

  localparam int unsigned NSRC  = 1 << SOURCE_W;
  localparam int unsigned CNT_W = 1 << SIZE_W;

  logic a_fire, d_fire, a_multi, d_multi, a_legal;
  logic a_first, a_last, d_first, d_last;
  logic [CNT_W-1:0]    a_beats, d_beats;
  logic [2:0]          a_lat_opcode, d_lat_opcode;
  logic [SIZE_W-1:0]   a_lat_size, d_lat_size;
  logic [SOURCE_W-1:0] a_lat_source, d_lat_source;
  logic                unused_a_last;

  assign a_fire  = a_valid && a_ready;
  assign d_fire  = d_valid && d_ready;
  assign a_multi = (a_opcode == A_PUT_FULL) || (a_opcode == A_PUT_PARTIAL);
  assign d_multi = (d_opcode == D_ACCESS_ACK_DATA);
  assign a_legal = a_multi || (a_opcode == A_GET);
  assign a_beats = CNT_W'(beat_count(32'(a_size), a_multi, BEAT_LOG2));
  assign d_beats = CNT_W'(beat_count(32'(d_size), d_multi, BEAT_LOG2));
  assign unused_a_last = a_last;

  tl_beat_counter #(.SIZE_W(SIZE_W), .SOURCE_W(SOURCE_W), .CNT_W(CNT_W)) u_a_beats (
    .clock(clock), .reset_n(reset_n), .fire(a_fire), .beats(a_beats),
    .opcode(a_opcode), .size(a_size), .source(a_source),
    .first(a_first), .last(a_last),
    .lat_opcode(a_lat_opcode), .lat_size(a_lat_size), .lat_source(a_lat_source)
  );

  tl_beat_counter #(.SIZE_W(SIZE_W), .SOURCE_W(SOURCE_W), .CNT_W(CNT_W)) u_d_beats (
    .clock(clock), .reset_n(reset_n), .fire(d_fire), .beats(d_beats),
    .opcode(d_opcode), .size(d_size), .source(d_source),
    .first(d_first), .last(d_last),
    .lat_opcode(d_lat_opcode), .lat_size(d_lat_size), .lat_source(d_lat_source)
  );

  logic [NSRC-1:0]   inflight, inflight_clr, inflight_nxt;
  logic [2:0]        rec_resp [NSRC];
  logic [SIZE_W-1:0] rec_size [NSRC];
  logic              a_set;

  assign a_set = a_fire && a_first && a_legal;

  // D-last clear is applied before the A-first set so a same-cycle reuse ends set.
  always_comb begin
    inflight_clr = inflight;
    if (d_fire && d_last) inflight_clr[d_source] = 1'b0;
    inflight_nxt = inflight_clr;
    if (a_set) inflight_nxt[a_source] = 1'b1;
  end

  logic [6:1]        flags;
  logic [2:0]        n_err;
  err_e              new_code;
  logic [SOURCE_W-1:0] new_source;
  logic [8:0]        count_sum;
  logic [SOURCE_W:0] pop_nxt;

  always_comb begin
    flags    = '0;
    flags[1] = a_fire && a_first && !a_legal;
    flags[2] = a_set && inflight_clr[a_source];
    flags[3] = a_fire && !a_first &&
               ((a_opcode != a_lat_opcode) || (a_size != a_lat_size) ||
                (a_source != a_lat_source));
    flags[4] = d_fire && d_first && !inflight[d_source];
    flags[5] = d_fire && d_first && inflight[d_source] &&
               ((d_opcode != rec_resp[d_source]) || (d_size != rec_size[d_source]));
    flags[6] = d_fire && !d_first &&
               ((d_opcode != d_lat_opcode) || (d_size != d_lat_size) ||
                (d_source != d_lat_source));

    n_err      = '0;
    new_code   = ERR_NONE;
    new_source = '0;
    // Descending scan so the lowest raised code is the one left standing.
    for (int unsigned i = 6; i >= 1; i--) begin
      n_err = n_err + 3'(flags[i]);
      if (flags[i]) begin
        new_code   = err_e'(3'(i));
        new_source = (i <= 3) ? a_source : d_source;
      end
    end
    count_sum = {1'b0, err_count} + 9'(n_err);

    pop_nxt = '0;
    for (int unsigned i = 0; i < NSRC; i++) pop_nxt = pop_nxt + (SOURCE_W+1)'(inflight_nxt[i]);
  end

  err_e err_code_q;
  assign err_code = err_code_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight       <= '0;
      inflight_count <= '0;
      err_valid      <= 1'b0;
      err_code_q     <= ERR_NONE;
      err_source     <= '0;
      err_count      <= '0;
      for (int unsigned i = 0; i < NSRC; i++) begin
        rec_resp[i] <= '0;
        rec_size[i] <= '0;
      end
    end else begin
      inflight       <= inflight_nxt;
      inflight_count <= pop_nxt;
      if (a_set) begin
        rec_resp[a_source] <= (a_opcode == A_GET) ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
        rec_size[a_source] <= a_size;
      end
      if ((n_err != '0) && (!err_valid || clear_err)) begin
        err_valid  <= 1'b1;
        err_code_q <= new_code;
        err_source <= new_source;
      end else if (clear_err) begin
        err_valid <= 1'b0;
      end
      err_count <= count_sum[8] ? 8'hFF : count_sum[7:0];
    end
  end

endmodule

// File: tb/tb_tl_inflight_monitor.sv
// Directed table-driven bench for tl_inflight_monitor plus hand-written
// sequences for asynchronous reset mid-burst and error-count saturation.
module tb_tl_inflight_monitor;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       a_valid, a_ready, d_valid, d_ready, clear_err;
  logic [2:0] a_opcode, d_opcode;
  logic [3:0] a_size, a_source, d_size, d_source;
  logic       err_valid;
  logic [2:0] err_code;
  logic [3:0] err_source;
  logic [7:0] err_count;
  logic [4:0] inflight_count;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  tl_inflight_monitor #(.SOURCE_W(4), .SIZE_W(4), .BEAT_LOG2(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
    .a_source(a_source),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source),
    .clear_err(clear_err),
    .err_valid(err_valid), .err_code(err_code), .err_source(err_source),
    .err_count(err_count), .inflight_count(inflight_count)
  );

  typedef struct {
    bit         rst;
    logic       av, ar;
    logic [2:0] aop;
    logic [3:0] asz, asrc;
    logic       dv, dr;
    logic [2:0] dop;
    logic [3:0] dsz, dsrc;
    logic       clr;
    logic       ev;
    logic [2:0] ec;
    logic [3:0] es;
    logic [7:0] ecnt;
    logic [4:0] einf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit rst,
                              input logic av, input logic ar, input logic [2:0] aop,
                              input logic [3:0] asz, input logic [3:0] asrc,
                              input logic dv, input logic dr, input logic [2:0] dop,
                              input logic [3:0] dsz, input logic [3:0] dsrc,
                              input logic clr,
                              input logic ev, input logic [2:0] ec, input logic [3:0] es,
                              input logic [7:0] ecnt, input logic [4:0] einf);
    vec_t v;
    v.rst = rst; v.av = av; v.ar = ar; v.aop = aop; v.asz = asz; v.asrc = asrc;
    v.dv = dv; v.dr = dr; v.dop = dop; v.dsz = dsz; v.dsrc = dsrc; v.clr = clr;
    v.ev = ev; v.ec = ec; v.es = es; v.ecnt = ecnt; v.einf = einf;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    a_valid = 0; a_ready = 1; a_opcode = 0; a_size = 0; a_source = 0;
    d_valid = 0; d_ready = 1; d_opcode = 0; d_size = 0; d_source = 0;
    clear_err = 0;
  endtask

  task automatic apply(input vec_t v);
    a_valid = v.av; a_ready = v.ar; a_opcode = v.aop; a_size = v.asz; a_source = v.asrc;
    d_valid = v.dv; d_ready = v.dr; d_opcode = v.dop; d_size = v.dsz; d_source = v.dsrc;
    clear_err = v.clr;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(err_valid), 0);
    check({tag, "_code"}, 32'(err_code), 0);
    check({tag, "_src"}, 32'(err_source), 0);
    check({tag, "_cnt"}, 32'(err_count), 0);
    check({tag, "_inf"}, 32'(inflight_count), 0);
  endtask

  initial begin
    idle();
    #1 reset_n = 0;
    #1 check_all_zero("async_reset");
    repeat (2) @(posedge clock);
    #1 reset_n = 1;
    check_all_zero("post_reset");

    //        rst av ar aop asz asrc dv dr dop dsz dsrc clr  ev ec es ecnt einf
    // Get / AccessAckData round trip
    vecs.push_back(mk(1, 1,1,4,2,3,  0,0,0,0,0,  0, 0,0,0,0,1));
    vecs.push_back(mk(0, 0,0,0,0,0,  1,1,1,2,3,  0, 0,0,0,0,0));
    // 4-beat PutFull, stall with garbage, size change on beat 3
    vecs.push_back(mk(1, 1,1,0,4,5,  0,0,0,0,0,  0, 0,0,0,0,1));
    vecs.push_back(mk(0, 1,0,0,7,5,  0,0,0,0,0,  0, 0,0,0,0,1));
    vecs.push_back(mk(0, 1,1,0,4,5,  0,0,0,0,0,  0, 0,0,0,0,1));
    vecs.push_back(mk(0, 1,1,0,3,5,  0,0,0,0,0,  0, 1,3,5,1,1));
    vecs.push_back(mk(0, 1,1,0,4,5,  0,0,0,0,0,  0, 1,3,5,1,1));
    vecs.push_back(mk(0, 0,0,0,0,0,  1,0,1,0,12, 0, 1,3,5,1,1));
    vecs.push_back(mk(0, 0,0,0,0,0,  1,1,0,4,5,  0, 1,3,5,1,0));
    // Duplicate source
    vecs.push_back(mk(1, 1,1,4,2,7,  0,0,0,0,0,  0, 0,0,0,0,1));
    vecs.push_back(mk(0, 1,1,4,2,7,  0,0,0,0,0,  0, 1,2,7,1,1));
    // Illegal opcode and unexpected D together, then a non-overwriting error
    vecs.push_back(mk(1, 1,1,6,0,1,  1,1,0,0,9,  0, 1,1,1,2,0));
    vecs.push_back(mk(0, 0,0,0,0,0,  1,1,0,0,9,  0, 1,1,1,3,0));
    // Response mismatch, clear, new error, clear colliding with error
    vecs.push_back(mk(1, 1,1,4,2,2,  0,0,0,0,0,  0, 0,0,0,0,1));
    vecs.push_back(mk(0, 0,0,0,0,0,  1,1,0,2,2,  0, 1,5,2,1,0));
    vecs.push_back(mk(0, 0,0,0,0,0,  0,0,0,0,0,  1, 0,0,0,1,0));
    vecs.push_back(mk(0, 0,0,0,0,0,  1,1,0,0,4,  0, 1,4,4,2,0));
    vecs.push_back(mk(0, 1,1,7,0,6,  0,0,0,0,0,  1, 1,1,6,3,0));
    // Same-cycle reuse of a source; D-first sees pre-set state
    vecs.push_back(mk(1, 1,1,4,2,8,  0,0,0,0,0,  0, 0,0,0,0,1));
    vecs.push_back(mk(0, 1,1,4,2,8,  1,1,1,2,8,  0, 0,0,0,0,1));
    vecs.push_back(mk(0, 0,0,0,0,0,  1,1,1,2,8,  0, 0,0,0,0,0));
    vecs.push_back(mk(0, 1,1,4,2,10, 1,1,1,2,10, 0, 1,4,10,1,1));
    // 4-beat AccessAckData with size change on beat 2
    vecs.push_back(mk(1, 1,1,4,4,1,  0,0,0,0,0,  0, 0,0,0,0,1));
    vecs.push_back(mk(0, 0,0,0,0,0,  1,1,1,4,1,  0, 0,0,0,0,1));
    vecs.push_back(mk(0, 0,0,0,0,0,  1,1,1,3,1,  0, 1,6,1,1,1));
    vecs.push_back(mk(0, 0,0,0,0,0,  1,1,1,4,1,  0, 1,6,1,1,1));
    vecs.push_back(mk(0, 0,0,0,0,0,  1,1,1,4,1,  0, 1,6,1,1,0));
    // PutPartial with size == BEAT_LOG2 is a single beat
    vecs.push_back(mk(1, 1,1,1,2,0,  0,0,0,0,0,  0, 0,0,0,0,1));
    vecs.push_back(mk(0, 1,1,4,2,1,  0,0,0,0,0,  0, 0,0,0,0,2));
    vecs.push_back(mk(0, 0,0,0,0,0,  1,1,0,2,0,  0, 0,0,0,0,1));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      apply(vecs[i]);
      tick();
      check($sformatf("row%0d_valid", i), 32'(err_valid), 32'(vecs[i].ev));
      check($sformatf("row%0d_cnt", i), 32'(err_count), 32'(vecs[i].ecnt));
      check($sformatf("row%0d_inf", i), 32'(inflight_count), 32'(vecs[i].einf));
      if (vecs[i].ev) begin
        check($sformatf("row%0d_code", i), 32'(err_code), 32'(vecs[i].ec));
        check($sformatf("row%0d_src", i), 32'(err_source), 32'(vecs[i].es));
      end
    end

    // Asynchronous reset in the middle of a 4-beat D burst
    do_reset();
    apply(mk(0, 1,1,4,4,3, 0,0,0,0,0, 0, 0,0,0,0,0)); tick(); idle();
    apply(mk(0, 0,0,0,0,0, 1,1,1,4,3, 0, 0,0,0,0,0)); tick();
    apply(mk(0, 0,0,0,0,0, 1,1,1,3,3, 0, 0,0,0,0,0)); tick();
    check("mid_burst_valid", 32'(err_valid), 1);
    check("mid_burst_inf", 32'(inflight_count), 1);
    #2 idle(); reset_n = 0;
    #1 check_all_zero("mid_burst_reset");
    reset_n = 1;
    apply(mk(0, 1,1,4,2,3, 0,0,0,0,0, 0, 0,0,0,0,0)); tick();
    check("fresh_get_inf", 32'(inflight_count), 1);
    check("fresh_get_valid", 32'(err_valid), 0);
    apply(mk(0, 0,0,0,0,0, 1,1,1,2,3, 0, 0,0,0,0,0)); tick();
    check_all_zero("fresh_ack");

    // Two errors per cycle until the count saturates
    do_reset();
    for (int i = 0; i < 129; i++) begin
      apply(mk(0, 1,1,6,0,0, 1,1,0,0,9, 0, 0,0,0,0,0));
      tick();
      if (i == 126) check("sat_254", 32'(err_count), 254);
      if (i == 127) check("sat_255", 32'(err_count), 255);
    end
    check("sat_hold", 32'(err_count), 255);
    check("sat_code", 32'(err_code), 1);
    check("sat_valid", 32'(err_valid), 1);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tl_inflight_monitor.md
TL_INFLIGHT_MONITOR -- requirements
Module: tl_inflight_monitor

Interface
REQ-001 SHALL have parameter SOURCE_W, default 4, width of source IDs (2^SOURCE_W tracked sources).
REQ-002 SHALL have parameter SIZE_W, default 4, width of the log2-bytes size field.
REQ-003 SHALL have parameter BEAT_LOG2, default 2, log2 of data-beat bytes.
REQ-004 clock  in  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 a_valid, a_ready  in  1 each  A-channel handshake; a_fire = both high.
REQ-007 a_opcode  in  3; a_size  in  SIZE_W; a_source  in  SOURCE_W  A-channel fields.
REQ-008 d_valid, d_ready  in  1 each  D-channel handshake; d_fire = both high.
REQ-009 d_opcode  in  3; d_size  in  SIZE_W; d_source  in  SOURCE_W  D-channel fields.
REQ-010 clear_err  in  1  clears captured error next cycle.
REQ-011 err_valid  out  1; err_code  out  3; err_source  out  SOURCE_W  first captured error.
REQ-012 err_count  out  8  saturating count of all detected errors.
REQ-013 inflight_count  out  SOURCE_W+1  number of outstanding sources.

Function
REQ-014 Beats per message SHALL be 2^(size-BEAT_LOG2) when size>BEAT_LOG2, else 1; PutFull(0)/PutPartial(1) on A and AccessAckData(1) on D are multi-beat, Get(4) and AccessAck(0) single-beat.
REQ-015 Each channel SHALL track first/last beat with a beat counter, latching opcode, size, source on the first beat.
REQ-016 A-first-beat fire SHALL set inflight[a_source] and record expected response (Get->1, Put->0) and size.
REQ-017 D-last-beat fire SHALL clear inflight[d_source].
REQ-018 Same-cycle D-last and A-first on the same source SHALL be legal: clear applied before set, bit ends set.
REQ-019 Error codes: 1 ILLEGAL_OPCODE (a_opcode not 0,1,4), 2 DUP_SOURCE (A-first to set bit), 3 A_BURST_CHANGE (non-first A beat fields differ from latched), 4 UNEXPECTED_D (D-first to clear bit), 5 RESP_MISMATCH (d_opcode or d_size differs from record), 6 D_BURST_CHANGE.
REQ-020 Checks SHALL be evaluated only on fire; same-cycle D-first sees inflight state before that cycle's A set.
REQ-021 With multiple errors in one cycle, lowest code SHALL be reported; err_count SHALL add the number of distinct errors, saturating at 255.
REQ-022 First error SHALL load err_valid/err_code/err_source one cycle after fire; later errors SHALL NOT overwrite while err_valid=1.
REQ-023 clear_err SHALL drop err_valid next cycle; a new error in the clear cycle SHALL be captured instead (error wins).
REQ-024 Illegal-opcode A messages SHALL NOT set inflight; DUP_SOURCE SHALL leave the bit set and overwrite record.
REQ-025 inflight_count SHALL be registered, equal to popcount of inflight after the same edge's updates.
REQ-026 Stall (valid without ready) SHALL NOT advance counters or raise errors.

Reset
REQ-027 reset_n low SHALL immediately clear inflight table, records, beat counters, err_valid, err_code, err_source, err_count, inflight_count to 0.
REQ-028 Reset mid-burst SHALL abandon the burst; first post-reset fire is a first beat.

Structure
REQ-029 Shared package tl_mon_pkg SHALL hold A/D opcode constants, error-code enum, and beat-count function.
REQ-030 One sub-module tl_beat_counter (first/last generation, field latch) SHALL be instantiated once per channel.

Verification
REQ-031 Get size=2 src=3, then AccessAckData size=2 src=3 -> inflight_count 1 then 0, err_valid=0.
REQ-032 PutFull size=4 (4 beats) src=5, a_size changed on beat 3 -> err_code=3, err_source=5, err_count=1.
REQ-033 Two Get src=7 without D -> err_code=2, err_source=7; inflight_count=1.
REQ-034 AccessAck src=9 with nothing inflight, same cycle a_opcode=6 -> err_code=1, err_count=2.
REQ-035 Get src=2 answered with AccessAck (0) -> err_code=5; then clear_err -> err_valid=0, err_count held at 1.
REQ-036 reset_n low mid 4-beat D burst -> all outputs 0 asynchronously; fresh Get/AckData pair passes clean.
